uart_tx_buf: RTL and testbench

Buffered 8N1 UART transmitter for the GY_MCU90640 thermal-sensor link. It serialises command bytes from the FPGA control logic onto the sensor's RX line at the same baud rate as the existing UART receiver. A one-entry holding register behind the shift register lets the upstream logic queue the next byte while the current frame is on the wire, so back-to-back frames go out with no idle gap.

---
 rtl/uart_tx_buf.sv | 153 +++++++++++++++
 tb/tb_uart_tx_buf.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered UART transmitter with a one-entry holding register
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit after DATA); default is 8N1.
module uart_tx_buf #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int          BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept, load, wrap;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  always_comb begin
    accept      = tx_valid & ~hold_full_q;
    wrap        = (clk_cnt_q == CNT_LAST);
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    load        = 1'b0;
    done_d      = 1'b0;
    clk_cnt_d   = (state_q == IDLE || wrap) ? 16'd0 : clk_cnt_q + 16'd1;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (wrap) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (wrap) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (wrap) state_d = STOP;
      end
`endif
      STOP: begin
        if (wrap) begin
          done_d = 1'b1;
          // Chain straight into the next start bit when a byte is already waiting.
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d = hold_q;
`ifdef UART_TX_PARITY_EN
      par_d   = ^hold_q;
`endif
    end

    // load and accept never coincide: accept needs an empty holding register.
    hold_d      = accept ? tx_data : hold_q;
    hold_full_d = load ? 1'b0 : (accept ? 1'b1 : hold_full_q);

    // Line level follows the state being entered so uart_txd stays a plain flop.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clk_cnt_q   <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign tx_ready = ~hold_full_q;
  assign uart_txd = txd_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - directed self-checking bench for uart_tx_buf
module tb_uart_tx_buf;

  localparam int BPS = 434;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk_50m = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, uart_txd, tx_busy, tx_done;
  int         n_checks = 0;
  int         n_errors = 0;

  uart_tx_buf dut (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .uart_txd (uart_txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Starts on the first cycle the start bit is on the line; ends on the tx_done cycle.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic e, obs, busy_bad, done_bad;
    busy_bad = 1'b0;
    done_bad = 1'b0;
    for (int i = 0; i < NB; i++) begin
      e   = exp_bit(b, i);
      obs = e;
      for (int c = 0; c < BPS; c++) begin
        if (uart_txd !== e) obs = uart_txd;
        if (tx_busy !== 1'b1) busy_bad = 1'b1;
        if (tx_done !== 1'b0 && !(i == 0 && c == 0)) done_bad = 1'b1;
        step();
      end
      check($sformatf("%s bit%0d", tag, i), obs, e);
    end
    check({tag, " busy"}, busy_bad, 1'b0);
    check({tag, " early done"}, done_bad, 1'b0);
    check({tag, " done pulse"}, tx_done, 1'b1);
  endtask

  task automatic send(input logic [7:0] b, input int budget);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check($sformatf("ready for %02h", b), tx_ready, 1'b1);
    tx_valid = 1'b1;
    tx_data  = b;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic uart_rx(output logic [7:0] b, output logic p);
    int n;
    n = 0;
    b = 8'h00;
    p = 1'b0;
    while (uart_txd !== 1'b0 && n < 3 * NB * BPS) begin
      step();
      n++;
    end
    check("rx start edge", uart_txd, 1'b0);
    repeat (BPS / 2) step();
    check("rx start mid", uart_txd, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (BPS) step();
      b[i] = uart_txd;
    end
`ifdef UART_TX_PARITY_EN
    repeat (BPS) step();
    p = uart_txd;
`endif
    repeat (BPS) step();
    check("rx stop", uart_txd, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       bad;
    logic [7:0] rb;
    logic       rp;
    logic [7:0] lb [4];
    lb = '{8'h00, 8'hFF, 8'h80, 8'h01};

    // Reset state and idle line
    repeat (3) step();
    check("rst txd", uart_txd, 1'b1);
    check("rst ready", tx_ready, 1'b1);
    check("rst busy", tx_busy, 1'b0);
    check("rst done", tx_done, 1'b0);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (1000) begin
      step();
      if (uart_txd !== 1'b1) bad = 1'b1;
    end
    check("idle line", bad, 1'b0);

    // Single byte 0x55: start bit from the cycle after accept
    send(8'h55, 10);
    check("ready after accept", tx_ready, 1'b0);
    step();
    check("ready after load", tx_ready, 1'b1);
    check_frame("b55", 8'h55);
    step();
    check("idle after 55", {tx_busy, uart_txd, tx_done}, 3'b010);

    // Back-to-back 0xA5, 0x3C with tx_valid held high
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    step();
    check("b2b first accept", tx_ready, 1'b0);
    tx_data = 8'h3C;
    fork
      begin
        step();
        check_frame("bA5", 8'hA5);
      end
      begin
        step();
        check("ready at A5 load", tx_ready, 1'b1);
        step();
        tx_valid = 1'b0;
        check("second accept", tx_ready, 1'b0);
        bad = 1'b0;
        for (int n = 0; n < NB * BPS - 2; n++) begin
          step();
          if (tx_ready !== 1'b0) bad = 1'b1;
        end
        check("ready low until 3C load", bad, 1'b0);
        step();
        check("ready at 3C load", tx_ready, 1'b1);
      end
    join
    check_frame("b3C", 8'h3C);
    step();
    check("idle after 3C", {tx_busy, uart_txd, tx_done}, 3'b010);

    // Backpressure: data churns while the holding register is full
    send(8'h11, 10);
    fork
      begin
        step();
        check_frame("b11", 8'h11);
        check_frame("b96", 8'h96);
      end
      begin
        step();
        send(8'h96, 5);
        tx_valid = 1'b1;
        for (int n = 1; n <= 100; n++) begin
          tx_data = 8'h96 ^ 8'(n);
          step();
        end
        tx_valid = 1'b0;
      end
    join
    step();
    check("idle after 96", {tx_busy, uart_txd, tx_done}, 3'b010);

    // Loopback through a mid-bit sampling receiver
    fork
      for (int i = 0; i < 4; i++) send(lb[i], NB * BPS + 10);
      for (int i = 0; i < 4; i++) begin
        uart_rx(rb, rp);
        check($sformatf("loopback %0d", i), rb, lb[i]);
      end
    join
`ifdef UART_TX_PARITY_EN
    fork
      begin
        send(8'h07, NB * BPS + 10);
        send(8'h03, NB * BPS + 10);
      end
      begin
        uart_rx(rb, rp);
        check("par 07 byte", rb, 8'h07);
        check("par 07 bit", rp, 1'b1);
        uart_rx(rb, rp);
        check("par 03 byte", rb, 8'h03);
        check("par 03 bit", rp, 1'b0);
      end
    join
`endif
    repeat (NB * BPS) step();

    // Reset during data bit 3 with a byte waiting in the holding register
    send(8'h00, 10);
    step();
    send(8'h5A, 5);
    repeat (4 * BPS + 200) step();
    check("mid-frame line low", uart_txd, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async txd high", uart_txd, 1'b1);
    check("async ready", tx_ready, 1'b1);
    check("async busy", tx_busy, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (500) begin
      step();
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    check("no residual frame", bad, 1'b0);
    check("ready after reset", tx_ready, 1'b1);
    send(8'hC3, 10);
    step();
    check_frame("bC3", 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
